// File: rtl/mem_responder_pkg.sv
// Shared widths and latency limits for the mem_responder memory model (also the define.v values).
// Optional range checking is selected by the MEM_RESP_RANGE_CHK_EN macro in mem_responder.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_RESP_MAX_LAT
`define MEM_RESP_MAX_LAT 4
`endif
`ifndef MEM_RESP_ADDR_BITS
`define MEM_RESP_ADDR_BITS 10
`endif
`ifndef MEM_RESP_RD_LATENCY
`define MEM_RESP_RD_LATENCY 2
`endif

package mem_responder_pkg;

  localparam int MEM_DW      = `DATA_WIDTH;
  localparam int MEM_MAX_LAT = `MEM_RESP_MAX_LAT;

  typedef logic [MEM_DW-1:0] mem_word_t;

  // Number of register stages between the launch capture and the output register.
  function automatic int pipe_stages(input int rd_latency);
    if (rd_latency < 1) return 0;
    if (rd_latency > MEM_MAX_LAT) return MEM_MAX_LAT - 1;
    return rd_latency - 1;
  endfunction

endpackage

// File: rtl/mem_resp_delay_line.sv
// Valid-tagged shift register carrying read words towards the output register.
// Only the valid bits are reset; the data stages are free-running.
module mem_resp_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    always_comb begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port word memory answering the mem_* strobes with fixed-latency, in-order read data.
// Define MEM_RESP_RANGE_CHK_EN to drop out-of-range writes, zero such reads and flag err_oob.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_RESP_MAX_LAT
`define MEM_RESP_MAX_LAT 4
`endif
`ifndef MEM_RESP_ADDR_BITS
`define MEM_RESP_ADDR_BITS 10
`endif
`ifndef MEM_RESP_RD_LATENCY
`define MEM_RESP_RD_LATENCY 2
`endif

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS  = `MEM_RESP_ADDR_BITS,
  parameter int RD_LATENCY = `MEM_RESP_RD_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [`DATA_WIDTH-1:0] mem_addr,
  input  logic [`DATA_WIDTH-1:0] mem_w_data,
  output logic [`DATA_WIDTH-1:0] mem_r_data,
  output logic                   rd_valid,
  output logic                   err_oob
);

  localparam int DW    = `DATA_WIDTH;
  localparam int WORDS = 1 << ADDR_BITS;
  localparam int PIPE  = pipe_stages(RD_LATENCY);

  if (RD_LATENCY < 1 || RD_LATENCY > `MEM_RESP_MAX_LAT) begin : g_bad_lat
    $error("mem_responder: RD_LATENCY=%0d outside 1..%0d", RD_LATENCY, `MEM_RESP_MAX_LAT);
  end

  logic [DW-1:0]        mem_q [WORDS];
  logic [ADDR_BITS-1:0] idx;
  logic                 oob;
  logic [DW-1:0]        rd_word;
  logic                 lat_valid;
  logic [DW-1:0]        lat_data;
  logic [DW-1:0]        mem_r_data_q, mem_r_data_d;
  logic                 rd_valid_q, rd_valid_d;

  assign idx = mem_addr[ADDR_BITS-1:0];

`ifdef MEM_RESP_RANGE_CHK_EN
  logic err_oob_q, err_oob_d;

  assign oob = |mem_addr[DW-1:ADDR_BITS];

  always_comb begin
    err_oob_d = err_oob_q | (oob & (mem_r_en | mem_w_en));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_oob_q <= 1'b0;
    else        err_oob_q <= err_oob_d;
  end

  assign err_oob = err_oob_q;
`else
  // Upper address bits alias onto the array when range checking is compiled out.
  logic unused_addr_hi;
  assign unused_addr_hi = |mem_addr[DW-1:ADDR_BITS];
  assign oob            = 1'b0;
  assign err_oob        = 1'b0;
`endif

  // Combinational array read sees the pre-edge contents, giving read-before-write.
  always_comb begin
    rd_word = mem_q[idx];
    if (oob) rd_word = '0;
  end

  always_ff @(posedge clk) begin
    if (mem_w_en && !oob) mem_q[idx] <= mem_w_data;
  end

  mem_resp_delay_line #(
    .WIDTH (DW),
    .DEPTH (PIPE)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (mem_r_en),
    .in_data   (rd_word),
    .out_valid (lat_valid),
    .out_data  (lat_data)
  );

  always_comb begin
    mem_r_data_d = mem_r_data_q;
    rd_valid_d   = lat_valid;
    if (lat_valid) mem_r_data_d = lat_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r_data_q <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      mem_r_data_q <= mem_r_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign mem_r_data = mem_r_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus queues expected read words with their due cycle,
// a negedge monitor pops and compares on every rd_valid pulse.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mem_responder;

  localparam int DW  = `DATA_WIDTH;
  localparam int AB  = 10;
  localparam int LAT = 2;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
    string         name;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          mem_r_en = 1'b0;
  logic          mem_w_en = 1'b0;
  logic [DW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_w_data = '0;
  logic [DW-1:0] mem_r_data;
  logic          rd_valid;
  logic          err_oob;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  mem_responder #(
    .ADDR_BITS  (AB),
    .RD_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data),
    .rd_valid   (rd_valid),
    .err_oob    (err_oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid: got data=%h at cycle %0d, required no pulse", mem_r_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (mem_r_data !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL %s: got data=%h cycle=%0d, required data=%h cycle=%0d",
                   e.name, mem_r_data, cyc, e.data, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic issue(input logic r, input logic w, input logic [DW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp, input string nm);
    mem_r_en   = r;
    mem_w_en   = w;
    mem_addr   = a;
    mem_w_data = wd;
    if (r) sb.push_back('{exp, cyc + LAT, nm});
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] a, input logic [DW-1:0] d);
    issue(1'b0, 1'b1, a, d, '0, "write");
  endtask

  task automatic rd(input logic [DW-1:0] a, input logic [DW-1:0] exp, input string nm);
    issue(1'b1, 1'b0, a, '0, exp, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_valid", {{(DW-1){1'b0}}, rd_valid}, '0);
    chk("reset_r_data", mem_r_data, '0);
    chk("reset_err_oob", {{(DW-1){1'b0}}, err_oob}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // write then immediate read of the same word, then verify the output holds
    wr(32'd3, 32'hA5A5_0001);
    rd(32'd3, 32'hA5A5_0001, "rd_after_wr");
    idle(5);
    @(negedge clk);
    chk("r_data_hold", mem_r_data, 32'hA5A5_0001);
    idle(1);

    // four back-to-back reads
    for (int i = 0; i < 4; i++) wr(i, 32'h10 + i);
    rd(32'd0, 32'h10, "b2b_0");
    rd(32'd1, 32'h11, "b2b_1");
    rd(32'd2, 32'h12, "b2b_2");
    rd(32'd3, 32'h13, "b2b_3");
    idle(4);

    // same-edge read and write: old word returned, new word afterwards
    wr(32'd5, 32'h11);
    issue(1'b1, 1'b1, 32'd5, 32'h22, 32'h11, "rw_same_edge_old");
    rd(32'd5, 32'h22, "rw_same_edge_new");
    idle(4);

    // reset one cycle after a read launch discards it; array survives
    wr(32'd7, 32'hCAFE_0007);
    idle(1);
    mem_r_en = 1'b1;
    mem_addr = 32'd7;
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_reset_rd_valid", {{(DW-1){1'b0}}, rd_valid}, '0);
    chk("mid_reset_r_data", mem_r_data, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    @(negedge clk);
    chk("post_reset_r_data", mem_r_data, '0);
    idle(1);
    rd(32'd7, 32'hCAFE_0007, "rd_persist_reset");
    idle(4);

    // out-of-range / aliasing access
    @(negedge clk);
    chk("err_oob_before", {{(DW-1){1'b0}}, err_oob}, '0);
    idle(1);
    wr(32'h000, 32'h77);
    wr(32'h400, 32'hDEAD);
`ifdef MEM_RESP_RANGE_CHK_EN
    rd(32'h400, 32'h0, "oob_read_zero");
    rd(32'h000, 32'h77, "oob_write_dropped");
    idle(4);
    @(negedge clk);
    chk("err_oob_set", {{(DW-1){1'b0}}, err_oob}, {{(DW-1){1'b0}}, 1'b1});
`else
    rd(32'h400, 32'hDEAD, "alias_read_hi");
    rd(32'h000, 32'hDEAD, "alias_read_lo");
    idle(4);
    @(negedge clk);
    chk("err_oob_tied", {{(DW-1){1'b0}}, err_oob}, '0);
`endif

    idle(6);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_rd_valid: %0d reads outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
